// File: rtl/time_bcd_sequencer.sv
// Sequential seconds -> packed BCD (MMM:SS) converter.
// One shift/subtract datapath is time-shared across three phases:
// restoring divide by 60, then minutes double-dabble, then seconds double-dabble.
module time_bcd_sequencer #(
  parameter int IN_BITS = 16,
  parameter int MAX_VAL = 60000
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic               CE,
  input  logic               START,
  input  logic [IN_BITS-1:0] SECS,
  output logic [31:0]        Q,
  output logic               BUSY,
  output logic               DONE
);

  localparam int CNT_W = ($clog2(IN_BITS) > 4) ? $clog2(IN_BITS) : 4;
  localparam logic [IN_BITS-1:0] MAX_M1 = IN_BITS'(MAX_VAL - 1);

  typedef enum logic [2:0] {S_IDLE, S_DIV, S_BCD_MIN, S_BCD_SEC, S_UPD} state_e;

  state_e             state_q, state_d;
  logic [IN_BITS-1:0] sh_q, sh_d;        // shared shift source, MSB consumed each step
  logic [6:0]         rem_q, rem_d;      // division remainder, ends up as seconds
  logic [9:0]         quo_q, quo_d;      // quotient, ends up as minutes
  logic [11:0]        acc_q, acc_d;      // double-dabble accumulator
  logic [11:0]        min_bcd_q, min_bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        q_q, q_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [7:0]         rem_w;
  logic               rem_ge;
  logic [6:0]         rem_nx;
  logic [9:0]         quo_nx;
  logic [11:0]        acc_adj, acc_sh;
  logic [IN_BITS-1:0] sec_in;

  // add 3 to every decade that is 5 or more before the shift
  function automatic logic [11:0] dab_adj(input logic [11:0] a);
    logic [11:0] r;
    r = a;
    for (int i = 0; i < 3; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  // shared datapath terms and next-state / work-register update
  always_comb begin
    rem_w   = {rem_q, sh_q[IN_BITS-1]};
    rem_ge  = (rem_w >= 8'd60);
    rem_nx  = 7'(rem_ge ? (rem_w - 8'd60) : rem_w);
    quo_nx  = 10'({quo_q, rem_ge});
    acc_adj = dab_adj(acc_q);
    acc_sh  = 12'({acc_adj, sh_q[IN_BITS-1]});
    sec_in  = (SECS > MAX_M1) ? MAX_M1 : SECS;

    state_d   = state_q;
    sh_d      = sh_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    acc_d     = acc_q;
    min_bcd_d = min_bcd_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    busy_d    = busy_q;
    done_d    = 1'b0;   // DONE is a single-CLK pulse even when CE is low

    if (CE) begin
      case (state_q)
        S_IDLE: if (START) begin
          sh_d    = sec_in;
          rem_d   = '0;
          quo_d   = '0;
          acc_d   = '0;
          cnt_d   = CNT_W'(IN_BITS - 1);
          busy_d  = 1'b1;
          state_d = S_DIV;
        end
        S_DIV: begin
          sh_d  = {sh_q[IN_BITS-2:0], 1'b0};
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            // quotient bits become the next shift source, MSB aligned
            sh_d    = IN_BITS'(quo_nx) << (IN_BITS - 10);
            acc_d   = '0;
            cnt_d   = CNT_W'(9);
            state_d = S_BCD_MIN;
          end
        end
        S_BCD_MIN: begin
          sh_d  = {sh_q[IN_BITS-2:0], 1'b0};
          acc_d = acc_sh;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            min_bcd_d = acc_sh;
            sh_d      = IN_BITS'(rem_q[5:0]) << (IN_BITS - 6);
            acc_d     = '0;
            cnt_d     = CNT_W'(5);
            state_d   = S_BCD_SEC;
          end
        end
        S_BCD_SEC: begin
          sh_d  = {sh_q[IN_BITS-2:0], 1'b0};
          acc_d = acc_sh;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = S_UPD;
        end
        S_UPD: begin
          q_d     = {4'h0, min_bcd_q, 8'h00, acc_q[7:0]};
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // all state registers, async active-low clear
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q   <= S_IDLE;
      sh_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      acc_q     <= '0;
      min_bcd_q <= '0;
      cnt_q     <= '0;
      q_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      acc_q     <= acc_d;
      min_bcd_q <= min_bcd_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign Q    = q_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_time_bcd_sequencer.sv
// Bench for time_bcd_sequencer: directed cases plus random values against an
// arithmetic reference (/60, %60, decimal digits).
module tb_time_bcd_sequencer;

  logic        CLK = 1'b0;
  logic        CLR, CE, START;
  logic [15:0] SECS;
  logic [31:0] Q;
  logic        BUSY, DONE;

  int n_run  = 0;
  int n_fail = 0;
  bit ce_half = 1'b0;

  time_bcd_sequencer dut (
    .CLK(CLK), .CLR(CLR), .CE(CE), .START(START), .SECS(SECS),
    .Q(Q), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // CE either held high or toggled so it is high on every 2nd rising edge
  always @(negedge CLK) CE = ce_half ? ~CE : 1'b1;

  function automatic logic [31:0] ref_q(input int s);
    int c, m, sc;
    c  = (s > 59999) ? 59999 : s;
    m  = c / 60;
    sc = c % 60;
    return {4'h0, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10),
            8'h00, 4'(sc / 10), 4'(sc % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one conversion: START held until a CE edge accepts it, then scrambled SECS;
  // optionally pulses START again mid-run; returns latencies and torn-display flag
  task automatic run_conv(input logic [15:0] v, input bit busy_pulse,
                          output logic [31:0] q_out, output int lat_ce,
                          output int lat_clk, output bit torn, output bit busy_ok);
    logic [31:0] q0;
    int guard;
    q0 = Q;
    SECS = v; START = 1'b1;
    guard = 0;
    do begin @(posedge CLK); guard++; end while (!CE && guard < 10);
    #1;
    START = 1'b0;
    SECS = 16'($urandom);
    busy_ok = BUSY;
    lat_ce = 0; lat_clk = 0; torn = 1'b0;
    while (!DONE && lat_clk < 300) begin
      @(posedge CLK);
      lat_clk++;
      if (CE) lat_ce++;
      #1;
      START = (busy_pulse && lat_ce >= 3 && lat_ce <= 8);
      if (!DONE && Q !== q0) torn = 1'b1;
    end
    START = 1'b0;
    q_out = Q;
  endtask

  initial begin
    logic [31:0] qo;
    int lce, lclk;
    bit torn, bok, saw_done;
    logic [15:0] v;

    CLR = 1'b0; CE = 1'b1; START = 1'b0; SECS = '0;
    #12;
    chk("reset_q", Q, 32'h0);
    chk("reset_busy", {31'd0, BUSY}, 32'd0);
    chk("reset_done", {31'd0, DONE}, 32'd0);
    @(negedge CLK); CLR = 1'b1;
    @(posedge CLK); #1;

    // basic conversion with exact latency
    run_conv(16'd754, 1'b0, qo, lce, lclk, torn, bok);
    chk("754_q", qo, ref_q(754));
    chk("754_q_const", qo, 32'h0012_0034);
    chk("754_lat", lclk, 33);
    chk("754_busy", {31'd0, bok}, 32'd1);
    chk("754_torn", {31'd0, torn}, 32'd0);
    @(posedge CLK); #1;
    chk("754_done_pulse", {31'd0, DONE}, 32'd0);
    chk("754_busy_clr", {31'd0, BUSY}, 32'd0);

    // async clear during a conversion
    SECS = 16'd9999; START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    repeat (5) @(posedge CLK);
    #3; CLR = 1'b0; #1;
    chk("async_q", Q, 32'h0);
    chk("async_busy", {31'd0, BUSY}, 32'd0);
    chk("async_done", {31'd0, DONE}, 32'd0);
    @(negedge CLK); CLR = 1'b1;
    saw_done = 1'b0;
    repeat (50) begin @(posedge CLK); #1; if (DONE) saw_done = 1'b1; end
    chk("async_no_done", {31'd0, saw_done}, 32'd0);
    run_conv(16'd5, 1'b0, qo, lce, lclk, torn, bok);
    chk("after_clr_5", qo, 32'h0000_0005);
    run_conv(16'd61, 1'b0, qo, lce, lclk, torn, bok);
    chk("after_clr_61", qo, 32'h0001_0001);

    // boundaries and clamp
    run_conv(16'd59999, 1'b0, qo, lce, lclk, torn, bok);
    chk("max", qo, 32'h0999_0059);
    run_conv(16'd65535, 1'b0, qo, lce, lclk, torn, bok);
    chk("clamp", qo, 32'h0999_0059);
    run_conv(16'd60000, 1'b0, qo, lce, lclk, torn, bok);
    chk("clamp_edge", qo, 32'h0999_0059);
    run_conv(16'd0, 1'b0, qo, lce, lclk, torn, bok);
    chk("zero", qo, 32'h0000_0000);
    run_conv(16'd59, 1'b0, qo, lce, lclk, torn, bok);
    chk("59", qo, 32'h0000_0059);
    run_conv(16'd60, 1'b0, qo, lce, lclk, torn, bok);
    chk("60", qo, 32'h0001_0000);
    run_conv(16'd599, 1'b0, qo, lce, lclk, torn, bok);
    chk("599", qo, 32'h0009_0059);

    // CE every 2nd clock, START pulses while busy, SECS changed after accept
    ce_half = 1'b1;
    repeat (4) @(posedge CLK); #1;
    run_conv(16'd3600, 1'b1, qo, lce, lclk, torn, bok);
    chk("ce_q", qo, 32'h0060_0000);
    chk("ce_lat_ce", lce, 33);
    chk("ce_lat_clk", lclk, 66);
    chk("ce_torn", {31'd0, torn}, 32'd0);
    saw_done = 1'b0;
    repeat (80) begin @(posedge CLK); #1; if (DONE || BUSY) saw_done = 1'b1; end
    chk("ce_no_requeue", {31'd0, saw_done}, 32'd0);

    // random values, mixed CE modes
    for (int i = 0; i < 24; i++) begin
      ce_half = 1'($urandom_range(0, 1));
      repeat (2) @(posedge CLK); #1;
      v = (i % 3 == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 60100));
      run_conv(v, 1'($urandom_range(0, 1)), qo, lce, lclk, torn, bok);
      chk($sformatf("rand_%0d_q", v), qo, ref_q(int'(v)));
      chk($sformatf("rand_%0d_lat", v), lce, 33);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
